// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: queues ALU and load results in a small
// FIFO, drains one entry per cycle into the file, and forwards pending data.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [2:0]               alu_adr,
  input  logic [15:0]              alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [2:0]               mem_adr,
  input  logic [15:0]              mem_data,
  input  logic                     wb_hold,
  output logic [15:0]              W,
  output logic [2:0]               W_Adr,
  output logic                     we,
  input  logic [2:0]               R_Adr,
  input  logic [2:0]               S_Adr,
  input  logic [15:0]              rf_R,
  input  logic [15:0]              rf_S,
  output logic [15:0]              R_fwd,
  output logic [15:0]              S_fwd,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]    r_adr  [DEPTH];
  logic [15:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_drain;
  logic          w_space;
  logic          w_mem_enq;
  logic          w_alu_enq;
  logic          w_enq;
  logic [2:0]    w_enq_adr;
  logic [15:0]   w_enq_data;

  // Reset gates the drain so no file write can happen on a reset edge.
  assign w_drain   = (r_count != '0) && !wb_hold && !reset;
  assign w_space   = (int'(r_count) < DEPTH) || w_drain || reset;
  assign mem_ready = w_space;
  assign alu_ready = w_space && !mem_valid;

  assign w_mem_enq  = mem_valid && mem_ready && !reset;
  assign w_alu_enq  = alu_valid && alu_ready && !reset;
  assign w_enq      = w_mem_enq || w_alu_enq;
  assign w_enq_adr  = w_mem_enq ? mem_adr  : alu_adr;
  assign w_enq_data = w_mem_enq ? mem_data : alu_data;

  assign we      = w_drain;
  assign W       = w_drain ? r_data[r_head] : 16'h0000;
  assign W_Adr   = w_drain ? r_adr[r_head]  : 3'd0;
  assign pending = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // When full and draining, the tail slot equals the head slot being
      // written out this cycle, so overwriting it here is safe.
      if (w_enq) begin
        r_adr[r_tail]  <= w_enq_adr;
        r_data[r_tail] <= w_enq_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_drain);
    end
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] v_idx;
    R_fwd = rf_R;
    S_fwd = rf_S;
    v_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_head + PW'(k);
      if (k < int'(r_count)) begin
        if (r_adr[v_idx] == R_Adr) R_fwd = r_data[v_idx];
        if (r_adr[v_idx] == S_Adr) S_fwd = r_data[v_idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus random traffic checked
// against a queue-based model of pending writes and the register file.
module tb_regfile_wb_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, wb_hold;
  logic        alu_ready, mem_ready, we;
  logic [2:0]  alu_adr, mem_adr, W_Adr, R_Adr, S_Adr;
  logic [15:0] alu_data, mem_data, W, rf_R, rf_S, R_fwd, S_fwd;
  logic [$clog2(DEPTH):0] pending;

  regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_adr(alu_adr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_adr(mem_adr), .mem_data(mem_data),
    .wb_hold(wb_hold), .W(W), .W_Adr(W_Adr), .we(we),
    .R_Adr(R_Adr), .S_Adr(S_Adr), .rf_R(rf_R), .rf_S(rf_S),
    .R_fwd(R_fwd), .S_fwd(S_fwd), .pending(pending)
  );

  always #5 clk = ~clk;

  // Model: pending writes as {adr, data}, oldest first, plus the file itself.
  logic [18:0] exp_q[$];
  logic [15:0] m_rf [8];
  logic        e_drain, e_space;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called after the caller has set this cycle's inputs.
  task automatic check_outputs(input string tag);
    int          cnt;
    logic [15:0] er, es;
    rf_R = m_rf[R_Adr];
    rf_S = m_rf[S_Adr];
    #2;
    cnt     = exp_q.size();
    e_drain = !reset && (cnt != 0) && !wb_hold;
    e_space = (cnt < DEPTH) || e_drain || reset;
    er = rf_R;
    es = rf_S;
    for (int i = 0; i < cnt; i++) begin
      if (exp_q[i][18:16] == R_Adr) er = exp_q[i][15:0];
      if (exp_q[i][18:16] == S_Adr) es = exp_q[i][15:0];
    end
    check({tag, ".mem_ready"}, 32'(mem_ready), 32'(e_space));
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'(e_space && !mem_valid));
    check({tag, ".we"},        32'(we),        32'(e_drain));
    check({tag, ".W"},         32'(W),         e_drain ? 32'(exp_q[0][15:0])  : 32'd0);
    check({tag, ".W_Adr"},     32'(W_Adr),     e_drain ? 32'(exp_q[0][18:16]) : 32'd0);
    check({tag, ".pending"},   32'(pending),   32'(cnt));
    check({tag, ".R_fwd"},     32'(R_fwd),     32'(er));
    check({tag, ".S_fwd"},     32'(S_fwd),     32'(es));
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
    end else begin
      if (e_drain) begin
        m_rf[exp_q[0][18:16]] = exp_q[0][15:0];
        void'(exp_q.pop_front());
      end
      if (mem_valid && e_space)                  exp_q.push_back({mem_adr, mem_data});
      else if (alu_valid && e_space && !mem_valid) exp_q.push_back({alu_adr, alu_data});
    end
    #1;
  endtask

  task automatic cycle(input string tag);
    check_outputs(tag);
    advance();
  endtask

  task automatic idle_inputs();
    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; wb_hold = 1'b0;
    alu_adr = 3'd0; alu_data = 16'h0; mem_adr = 3'd0; mem_data = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle("rst");
    cycle("rst");
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = 16'(i * 16'h0101);
    R_Adr = 3'd0; S_Adr = 3'd1;
    do_reset();
    check_outputs("post_rst");
    check("post_rst.pending_zero", 32'(pending), 32'd0);
    check("post_rst.we_zero", 32'(we), 32'd0);
    advance();

    // Single write, one-cycle latency.
    idle_inputs();
    alu_valid = 1'b1; alu_adr = 3'd3; alu_data = 16'h1234;
    cycle("single.enq");
    alu_valid = 1'b0;
    check_outputs("single.wr");
    check("single.we", 32'(we), 32'd1);
    check("single.W_Adr", 32'(W_Adr), 32'd3);
    check("single.W", 32'(W), 32'h1234);
    advance();
    check_outputs("single.after");
    check("single.we_low", 32'(we), 32'd0);
    check("single.pending", 32'(pending), 32'd0);
    advance();

    // Contention: mem wins, alu follows a cycle later.
    mem_valid = 1'b1; mem_adr = 3'd1; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_adr = 3'd2; alu_data = 16'h5555;
    check_outputs("cont.both");
    check("cont.mem_ready", 32'(mem_ready), 32'd1);
    check("cont.alu_ready", 32'(alu_ready), 32'd0);
    advance();
    mem_valid = 1'b0;
    check_outputs("cont.alu");
    check("cont.first_W", 32'(W), 32'hAAAA);
    check("cont.alu_ready2", 32'(alu_ready), 32'd1);
    advance();
    alu_valid = 1'b0;
    check_outputs("cont.second");
    check("cont.second_W", 32'(W), 32'h5555);
    advance();

    // Fill under hold, then release and drain in order.
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_adr = 3'(i + 4); alu_data = 16'(16'hC000 + i);
      cycle("fill.enq");
    end
    alu_valid = 1'b1;
    check_outputs("fill.full");
    check("fill.pending", 32'(pending), 32'd4);
    check("fill.alu_ready", 32'(alu_ready), 32'd0);
    check("fill.mem_ready", 32'(mem_ready), 32'd0);
    advance();
    alu_valid = 1'b0; wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_outputs("fill.drain");
      check("fill.order_adr", 32'(W_Adr), 32'(i + 4));
      check("fill.order_we", 32'(we), 32'd1);
      advance();
    end

    // Forwarding of the youngest pending value.
    m_rf[5] = 16'hFFFF;
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_adr = 3'd5; alu_data = 16'h0001;
    cycle("fwd.enq1");
    alu_data = 16'h0002;
    cycle("fwd.enq2");
    alu_valid = 1'b0; R_Adr = 3'd5; S_Adr = 3'd4;
    check_outputs("fwd.read");
    check("fwd.R_fwd", 32'(R_fwd), 32'h0002);
    check("fwd.S_fwd", 32'(S_fwd), 32'(m_rf[4]));
    advance();

    // Full plus drain, pointers wrapping.
    alu_valid = 1'b1; alu_adr = 3'd6; alu_data = 16'h0E01;
    cycle("fd.enq");
    alu_data = 16'h0E02;
    cycle("fd.enq");
    alu_valid = 1'b0;
    wb_hold = 1'b0; mem_valid = 1'b1; mem_adr = 3'd7; mem_data = 16'hD000;
    check_outputs("fd.full_drain");
    check("fd.mem_ready", 32'(mem_ready), 32'd1);
    check("fd.pending", 32'(pending), 32'd4);
    advance();
    for (int i = 1; i <= 3; i++) begin
      mem_adr = 3'(i); mem_data = 16'(16'hD000 + i);
      check_outputs("fd.wrap");
      check("fd.pending_steady", 32'(pending), 32'd4);
      advance();
    end
    mem_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle("fd.empty");

    // Reset in the middle of operation.
    wb_hold = 1'b1; alu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_adr = 3'(i); alu_data = 16'(16'h7700 + i);
      cycle("rmid.enq");
    end
    alu_valid = 1'b0; wb_hold = 1'b0; reset = 1'b1;
    check_outputs("rmid.rst");
    check("rmid.pending_before", 32'(pending), 32'd3);
    advance();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      R_Adr = 3'(r);
      check_outputs("rmid.after");
      check("rmid.pending", 32'(pending), 32'd0);
      check("rmid.we", 32'(we), 32'd0);
      check("rmid.R_pass", 32'(R_fwd), 32'(rf_R));
      advance();
    end

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      mem_valid = ($urandom_range(0, 2) == 0);
      alu_valid = ($urandom_range(0, 1) == 0);
      wb_hold   = ($urandom_range(0, 3) == 0);
      mem_adr   = 3'($urandom_range(0, 7));
      alu_adr   = 3'($urandom_range(0, 7));
      mem_data  = 16'($urandom);
      alu_data  = 16'($urandom);
      R_Adr     = 3'($urandom_range(0, 7));
      S_Adr     = 3'($urandom_range(0, 7));
      cycle("rand");
    end

    // Let everything drain, then confirm the file holds the model's view.
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) cycle("final.drain");
    for (int r = 0; r < 8; r++) begin
      R_Adr = 3'(r); S_Adr = 3'(7 - r);
      check_outputs("final.read");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
